// File: rtl/sobel_window_gen_if.sv
// -----------------------------------------------------------------------------
// sobel_window_gen_if
//   Bundles the pixel-input handshake and the window-output handshake of the
//   3x3 neighbourhood generator.
//
//   Input side  : in_valid / in_ready / in_sof / in_pixel[7:0]
//   Output side : out_valid / out_ready, the eight neighbours p0..p8 (no p4),
//                 out_row / out_col of the window centre, frame_done pulse.
//
//   slave  : view taken by sobel_window_gen itself.
//   master : view taken by whatever feeds pixels and consumes windows.
// -----------------------------------------------------------------------------
interface sobel_window_gen_if #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9
);
    logic                in_valid;
    logic                in_ready;
    logic                in_sof;
    logic [7:0]          in_pixel;

    logic                out_valid;
    logic                out_ready;
    logic [7:0]          p0;
    logic [7:0]          p1;
    logic [7:0]          p2;
    logic [7:0]          p3;
    logic [7:0]          p5;
    logic [7:0]          p6;
    logic [7:0]          p7;
    logic [7:0]          p8;
    logic [ROW_BITS-1:0] out_row;
    logic [COL_BITS-1:0] out_col;
    logic                frame_done;

    modport slave (
        input  in_valid, in_sof, in_pixel, out_ready,
        output in_ready, out_valid, p0, p1, p2, p3, p5, p6, p7, p8,
               out_row, out_col, frame_done
    );

    modport master (
        output in_valid, in_sof, in_pixel, out_ready,
        input  in_ready, out_valid, p0, p1, p2, p3, p5, p6, p7, p8,
               out_row, out_col, frame_done
    );
endinterface

// File: rtl/sobel_window_gen.sv
// -----------------------------------------------------------------------------
// sobel_window_gen
//   Streaming 3x3 neighbourhood generator for a raster-order 8-bit pixel
//   stream. Two line buffers hold the previous two lines; a pair of stored
//   columns per window row, plus the column being accepted, form the 3x3
//   neighbourhood. Only interior pixels produce a window; the eight
//   neighbours (centre excluded) are presented on a single registered output
//   stage with valid/ready flow control.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   bus.in_valid / bus.in_ready / bus.in_sof / bus.in_pixel : pixel input
//   bus.out_valid / bus.out_ready                          : window handshake
//   bus.p0..p2 : top row (left, centre, right)
//   bus.p3,p5  : middle row (left, right)
//   bus.p6..p8 : bottom row (left, centre, right)
//   bus.out_row / bus.out_col : position of the window centre
//   bus.frame_done : one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_BITS   = 10,
    parameter int ROW_BITS   = 9
) (
    input  logic              clk,
    input  logic              rst,
    sobel_window_gen_if.slave bus
);

    localparam int DATA_W = 8;
    localparam int ADDR_W = $clog2(IMG_WIDTH);

    localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(IMG_HEIGHT - 1);
    localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
    localparam logic [ROW_BITS-1:0] ROW_ONE  = ROW_BITS'(1);
    localparam logic [COL_BITS-1:0] COL_TWO  = COL_BITS'(2);
    localparam logic [ROW_BITS-1:0] ROW_TWO  = ROW_BITS'(2);

    // Raster position of the next pixel to be accepted.
    logic [COL_BITS-1:0] r_col;
    logic [ROW_BITS-1:0] r_row;

    // Line buffers: line0 holds the previous line, line1 the one before it.
    // Not reset: border skipping guarantees every word read into a window
    // was written earlier in the same frame.
    logic [DATA_W-1:0]   r_line0 [IMG_WIDTH];
    logic [DATA_W-1:0]   r_line1 [IMG_WIDTH];

    // Column shift registers per window row. _c0 is two columns back (left),
    // _c1 one column back (centre); the right column is the one being
    // accepted this cycle, so it never needs a register of its own.
    logic [DATA_W-1:0]   r_top_c0, r_top_c1;
    logic [DATA_W-1:0]   r_mid_c0, r_mid_c1;
    logic [DATA_W-1:0]   r_bot_c0, r_bot_c1;

    // Output stage.
    logic                r_vld_p1;
    logic [DATA_W-1:0]   r_p0_p1, r_p1_p1, r_p2_p1;
    logic [DATA_W-1:0]   r_p3_p1, r_p5_p1;
    logic [DATA_W-1:0]   r_p6_p1, r_p7_p1, r_p8_p1;
    logic [ROW_BITS-1:0] r_row_p1;
    logic [COL_BITS-1:0] r_col_p1;
    logic                r_frame_done;

    logic                w_accept;
    logic [COL_BITS-1:0] w_col;
    logic [ROW_BITS-1:0] w_row;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_l0;
    logic [DATA_W-1:0]   w_l1;
    logic                w_last_col;
    logic                w_last_row;
    logic                w_emit;

    // A single output register: a new pixel may enter whenever the current
    // window is absent or leaves on this same edge, so there is no bubble.
    assign bus.in_ready = !rst && (!r_vld_p1 || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

    // in_sof re-anchors the accepted pixel at (0,0) regardless of counters.
    assign w_col      = bus.in_sof ? '0 : r_col;
    assign w_row      = bus.in_sof ? '0 : r_row;
    assign w_addr     = w_col[ADDR_W-1:0];
    assign w_last_col = (w_col == LAST_COL);
    assign w_last_row = (w_row == LAST_ROW);

    // Read-before-write: both reads see the contents prior to this edge.
    assign w_l1 = r_line1[w_addr];
    assign w_l0 = r_line0[w_addr];

    // The col>=2 test also discards the stale left columns left over from
    // the previous line, so a window never straddles a line wrap.
    assign w_emit = (w_row >= ROW_TWO) && (w_col >= COL_TWO);

    // ---- stage p0: raster counters and column shift registers ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= '0;
            r_row    <= '0;
            r_top_c0 <= '0;
            r_top_c1 <= '0;
            r_mid_c0 <= '0;
            r_mid_c1 <= '0;
            r_bot_c0 <= '0;
            r_bot_c1 <= '0;
        end else if (w_accept) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : (w_row + ROW_ONE);
            end else begin
                r_col <= w_col + COL_ONE;
                r_row <= w_row;
            end
            r_top_c0 <= r_top_c1;
            r_top_c1 <= w_l1;
            r_mid_c0 <= r_mid_c1;
            r_mid_c1 <= w_l0;
            r_bot_c0 <= r_bot_c1;
            r_bot_c1 <= bus.in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line1[w_addr] <= w_l0;
            r_line0[w_addr] <= bus.in_pixel;
        end
    end

    // ---- stage p1: registered window output ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1     <= 1'b0;
            r_frame_done <= 1'b0;
            r_p0_p1      <= '0;
            r_p1_p1      <= '0;
            r_p2_p1      <= '0;
            r_p3_p1      <= '0;
            r_p5_p1      <= '0;
            r_p6_p1      <= '0;
            r_p7_p1      <= '0;
            r_p8_p1      <= '0;
            r_row_p1     <= '0;
            r_col_p1     <= '0;
        end else begin
            r_frame_done <= w_accept && w_last_row && w_last_col;
            if (w_accept && w_emit) begin
                // Right-hand column comes straight from the line-buffer
                // reads and the incoming pixel.
                r_vld_p1 <= 1'b1;
                r_p0_p1  <= r_top_c0;
                r_p1_p1  <= r_top_c1;
                r_p2_p1  <= w_l1;
                r_p3_p1  <= r_mid_c0;
                r_p5_p1  <= w_l0;
                r_p6_p1  <= r_bot_c0;
                r_p7_p1  <= r_bot_c1;
                r_p8_p1  <= bus.in_pixel;
                r_row_p1 <= w_row - ROW_ONE;
                r_col_p1 <= w_col - COL_ONE;
            end else if (bus.out_ready) begin
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = r_vld_p1;
    assign bus.p0         = r_p0_p1;
    assign bus.p1         = r_p1_p1;
    assign bus.p2         = r_p2_p1;
    assign bus.p3         = r_p3_p1;
    assign bus.p5         = r_p5_p1;
    assign bus.p6         = r_p6_p1;
    assign bus.p7         = r_p7_p1;
    assign bus.p8         = r_p8_p1;
    assign bus.out_row    = r_row_p1;
    assign bus.out_col    = r_col_p1;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_sobel_window_gen.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_gen
//   Two instances: a 4x4 image (instance 0) and a 5x3 image (instance 1).
//   Each instance has a frame-array model that places every accepted pixel
//   by its linear index in the frame and derives the expected window from
//   the stored image; a per-instance monitor compares on every cycle.
//   Directed tests then pin literal window values.
// -----------------------------------------------------------------------------
module tb_sobel_window_gen;

    typedef struct packed {
        logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
        logic [3:0] row;
        logic [3:0] col;
        logic       fd;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;

    int n_vec = 0;
    int n_bad = 0;
    int fd_cnt [2] = '{0, 0};

    logic       s_vld  [2];
    logic       s_sof  [2];
    logic       s_ordy [2];
    logic [7:0] s_pix  [2];

    logic       w_rdy  [2];
    logic       w_ovld [2];
    logic [7:0] w_p0   [2];
    logic [7:0] w_p8   [2];

    win_t log0 [$];
    win_t log1 [$];

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic win_t mkw(input int a0, input int a1, input int a2, input int a3,
                                 input int a5, input int a6, input int a7, input int a8,
                                 input int r, input int c, input bit fd);
        win_t w;
        w.p0 = 8'(a0); w.p1 = 8'(a1); w.p2 = 8'(a2); w.p3 = 8'(a3);
        w.p5 = 8'(a5); w.p6 = 8'(a6); w.p7 = 8'(a7); w.p8 = 8'(a8);
        w.row = 4'(r); w.col = 4'(c); w.fd = fd;
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : 5;
        localparam int H = (g == 0) ? 4 : 3;

        sobel_window_gen_if #(.COL_BITS(3), .ROW_BITS(3)) bus ();

        assign bus.in_valid  = s_vld[g];
        assign bus.in_sof    = s_sof[g];
        assign bus.in_pixel  = s_pix[g];
        assign bus.out_ready = s_ordy[g];
        assign w_rdy[g]      = bus.in_ready;
        assign w_ovld[g]     = bus.out_valid;
        assign w_p0[g]       = bus.p0;
        assign w_p8[g]       = bus.p8;

        sobel_window_gen #(
            .IMG_WIDTH (W),
            .IMG_HEIGHT(H),
            .COL_BITS  (3),
            .ROW_BITS  (3)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        // Model state: the image as stored so far, the linear index of the
        // next pixel, and what the output stage should show this cycle.
        logic [7:0] img [H][W];
        int   pos = 0;
        bit   ev  = 1'b0;
        bit   efd = 1'b0;
        win_t ew;

        always @(negedge clk) begin
            win_t dw;
            bit   acc;
            int   r, c;
            dw.p0 = bus.p0; dw.p1 = bus.p1; dw.p2 = bus.p2; dw.p3 = bus.p3;
            dw.p5 = bus.p5; dw.p6 = bus.p6; dw.p7 = bus.p7; dw.p8 = bus.p8;
            dw.row = {1'b0, bus.out_row};
            dw.col = {1'b0, bus.out_col};
            dw.fd  = 1'b0;
            if (chk_en) begin
                chk($sformatf("u%0d out_valid", g), bus.out_valid, ev);
                chk($sformatf("u%0d in_ready", g), bus.in_ready, !rst && (!ev || s_ordy[g]));
                chk($sformatf("u%0d frame_done", g), bus.frame_done, efd);
                if (bus.frame_done === 1'b1) fd_cnt[g]++;
                if (ev) begin
                    chk($sformatf("u%0d window", g), dw, ew);
                    if (s_ordy[g] && !rst) begin
                        dw.fd = bus.frame_done;
                        if (g == 0) log0.push_back(dw);
                        else        log1.push_back(dw);
                    end
                end
            end
            if (rst) begin
                pos = 0;
                ev  = 1'b0;
                efd = 1'b0;
            end else begin
                acc = s_vld[g] && (!ev || s_ordy[g]);
                efd = 1'b0;
                if (ev && s_ordy[g]) ev = 1'b0;
                if (acc) begin
                    if (s_sof[g]) pos = 0;
                    r = pos / W;
                    c = pos % W;
                    img[r][c] = s_pix[g];
                    if (r >= 2 && c >= 2) begin
                        ev = 1'b1;
                        ew = mkw(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                                 img[r-1][c-2], img[r-1][c],
                                 img[r][c-2], img[r][c-1], img[r][c],
                                 r - 1, c - 1, 1'b0);
                    end
                    if (pos == W * H - 1) efd = 1'b1;
                    pos = (pos + 1) % (W * H);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int g, input int pix, input bit sof);
        bit took;
        s_vld[g] = 1'b1;
        s_pix[g] = 8'(pix);
        s_sof[g] = sof;
        took = 1'b0;
        for (int i = 0; i < 200 && !took; i++) begin
            @(negedge clk);
            took = w_rdy[g];
            @(posedge clk);
            #1;
        end
        if (!took) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: u%0d pixel %0d not accepted within 200 cycles", g, pix);
        end
        s_vld[g] = 1'b0;
        s_sof[g] = 1'b0;
    endtask

    task automatic send_frame(input int g, input int base, input int n, input bit sof_first);
        for (int i = 0; i < n; i++) send(g, base + i, sof_first && (i == 0));
    endtask

    // Expected windows of a 4x4 frame holding base+0 .. base+15.
    task automatic check_frame4(input string nm, input int k, input int b);
        if (log0.size() < k + 4) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_count: got %0d windows required at least %0d", nm, log0.size(), k + 4);
        end else begin
            chk({nm, "_w11"}, log0[k],   mkw(b+0, b+1, b+2, b+4,  b+6,  b+8,  b+9,  b+10, 1, 1, 1'b0));
            chk({nm, "_w12"}, log0[k+1], mkw(b+1, b+2, b+3, b+5,  b+7,  b+9,  b+10, b+11, 1, 2, 1'b0));
            chk({nm, "_w21"}, log0[k+2], mkw(b+4, b+5, b+6, b+8,  b+10, b+12, b+13, b+14, 2, 1, 1'b0));
            chk({nm, "_w22"}, log0[k+3], mkw(b+5, b+6, b+7, b+9,  b+11, b+13, b+14, b+15, 2, 2, 1'b1));
        end
    endtask

    initial begin
        int f0;
        bit seen;
        for (int g = 0; g < 2; g++) begin
            s_vld[g]  = 1'b0;
            s_sof[g]  = 1'b0;
            s_pix[g]  = 8'd0;
            s_ordy[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", w_ovld[0], 1'b0);
        chk("reset_p0", w_p0[0], 8'd0);
        @(posedge clk);
        #1;

        // Clean 4x4 frame.
        log0.delete();
        f0 = fd_cnt[0];
        send_frame(0, 0, 16, 1'b1);
        idle(4);
        chk("t1_windows", log0.size(), 4);
        check_frame4("t1", 0, 0);
        chk("t1_frame_done", fd_cnt[0] - f0, 1);

        // Backpressure on the first window.
        log0.delete();
        s_ordy[0] = 1'b0;
        fork
            send_frame(0, 0, 16, 1'b1);
            begin
                seen = 1'b0;
                for (int i = 0; i < 100 && !seen; i++) begin
                    @(negedge clk);
                    seen = w_ovld[0];
                end
                chk("t2_window_seen", seen, 1'b1);
                for (int i = 0; i < 5; i++) begin
                    chk("t2_hold_p0", w_p0[0], 8'd0);
                    chk("t2_hold_p8", w_p8[0], 8'd10);
                    chk("t2_hold_in_ready", w_rdy[0], 1'b0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                s_ordy[0] = 1'b1;
            end
        join
        idle(4);
        chk("t2_windows", log0.size(), 4);
        check_frame4("t2", 0, 0);

        // Back-to-back frames, the second without in_sof.
        log0.delete();
        f0 = fd_cnt[0];
        send_frame(0, 0, 16, 1'b1);
        send_frame(0, 100, 16, 1'b0);
        idle(4);
        chk("t3_windows", log0.size(), 8);
        check_frame4("t3a", 0, 0);
        check_frame4("t3b", 4, 100);
        chk("t3_frame_done", fd_cnt[0] - f0, 2);

        // Resync: six junk pixels, then in_sof on the seventh.
        log0.delete();
        for (int i = 0; i < 6; i++) send(0, 200 + i, 1'b0);
        send_frame(0, 0, 16, 1'b1);
        idle(4);
        chk("t4_windows", log0.size(), 4);
        check_frame4("t4", 0, 0);

        // Reset after nine pixels, then a full frame with no in_sof.
        send_frame(0, 50, 9, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", w_rdy[0], 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_after_rst_out_valid", w_ovld[0], 1'b0);
        @(posedge clk);
        #1;
        log0.delete();
        send_frame(0, 0, 16, 1'b0);
        idle(4);
        chk("t5_windows", log0.size(), 4);
        check_frame4("t5", 0, 0);

        // Gapped input on the 5x3 instance, all pixels 255.
        log1.delete();
        f0 = fd_cnt[1];
        for (int i = 0; i < 15; i++) begin
            idle($urandom_range(0, 3));
            send(1, 255, i == 0);
        end
        idle(4);
        chk("t6_windows", log1.size(), 3);
        if (log1.size() >= 3) begin
            chk("t6_w11", log1[0], mkw(255, 255, 255, 255, 255, 255, 255, 255, 1, 1, 1'b0));
            chk("t6_w12", log1[1], mkw(255, 255, 255, 255, 255, 255, 255, 255, 1, 2, 1'b0));
            chk("t6_w13", log1[2], mkw(255, 255, 255, 255, 255, 255, 255, 255, 1, 3, 1'b1));
        end
        chk("t6_frame_done", fd_cnt[1] - f0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
